// File: rtl/srcf_pkg.sv
// rtl/srcf_pkg.sv - shared sample-rate-converter encodings and register-file defaults
package srcf_pkg;

   // Register-file operations issued by the controller
   typedef enum logic [3:0] {
      ULOAD_SAMPLE = 4'b1000,
      CALC_INIT    = 4'b0101,
      LOAD_ERROR   = 4'b0010,
      LOAD_RESULT  = 4'b0001
   } rf_op_e;

   localparam int DEF_WIDTH  = 3;
   localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - registered read port selecting from the next-state register image
module regfile_rdport
   import srcf_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic                                 re,
   input  logic [WIDTH-1:0]                     ar,
   input  logic [2**WIDTH-1:0][DATA_W-1:0]      nxt,
   output logic [DATA_W-1:0]                    rd
);

   // Selecting from the next-state image makes the read write-first and shift-aware
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd <= '0;
      end else if (en && re) begin
         rd <= nxt[ar];
      end
   end

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with a sample delay line in the low registers
module regfile_2r1w
   import srcf_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SHIFT_N = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              re1,
   input  logic [WIDTH-1:0]  ar1,
   input  logic              re2,
   input  logic [WIDTH-1:0]  ar2,
   input  logic              we,
   input  logic [WIDTH-1:0]  ard,
   input  logic [DATA_W-1:0] wd,
   input  logic              shift,
   input  logic [DATA_W-1:0] sample_in,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              rd_valid
);

   localparam int DEPTH = 2**WIDTH;

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [DEPTH-1:0][DATA_W-1:0] nxt;

   // Write overrides shift; registers at or above SHIFT_N only ever take writes
   for (genvar k = 0; k < DEPTH; k++) begin : g_next
      localparam logic [WIDTH-1:0] K = WIDTH'(k);
      logic [DATA_W-1:0] base;
      if (k == 0) begin : g_head
         assign base = shift ? sample_in : mem[k];
      end else if (k < SHIFT_N) begin : g_line
         assign base = shift ? mem[k-1] : mem[k];
      end else begin : g_fixed
         assign base = mem[k];
      end
      assign nxt[k] = (we && (ard == K)) ? wd : base;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem      <= '0;
         rd_valid <= 1'b0;
      end else if (en) begin
         mem      <= nxt;
         rd_valid <= re1 | re2;
      end
   end

   regfile_rdport #(.WIDTH(WIDTH), .DATA_W(DATA_W)) u_rdport1 (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .re  (re1),
      .ar  (ar1),
      .nxt (nxt),
      .rd  (rd1)
   );

   regfile_rdport #(.WIDTH(WIDTH), .DATA_W(DATA_W)) u_rdport2 (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .re  (re2),
      .ar  (ar2),
      .nxt (nxt),
      .rd  (rd2)
   );

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - scoreboard bench for regfile_2r1w
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        re1 = 1'b0;
   logic [2:0]  ar1 = '0;
   logic        re2 = 1'b0;
   logic [2:0]  ar2 = '0;
   logic        we = 1'b0;
   logic [2:0]  ard = '0;
   logic [15:0] wd = '0;
   logic        shift = 1'b0;
   logic [15:0] sample_in = '0;
   logic [15:0] rd1;
   logic [15:0] rd2;
   logic        rd_valid;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic        v;
      logic [15:0] d1;
      logic [15:0] d2;
   } exp_t;

   exp_t sb[$];

   regfile_2r1w #(.WIDTH(3), .DATA_W(16), .SHIFT_N(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .re1       (re1),
      .ar1       (ar1),
      .re2       (re2),
      .ar2       (ar2),
      .we        (we),
      .ard       (ard),
      .wd        (wd),
      .shift     (shift),
      .sample_in (sample_in),
      .rd1       (rd1),
      .rd2       (rd2),
      .rd_valid  (rd_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: results of each posedge are compared on the following negedge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, ".rd_valid"}, {15'd0, rd_valid}, {15'd0, e.v});
            chk({e.name, ".rd1"}, rd1, e.d1);
            chk({e.name, ".rd2"}, rd2, e.d2);
         end
      end
   end

   task automatic step(input string name,
                       input logic e, input logic r1, input logic [2:0] a1,
                       input logic r2, input logic [2:0] a2,
                       input logic w, input logic [2:0] wa, input logic [15:0] wdat,
                       input logic s, input logic [15:0] sin,
                       input logic ev, input logic [15:0] e1, input logic [15:0] e2);
      exp_t x;
      en = e; re1 = r1; ar1 = a1; re2 = r2; ar2 = a2;
      we = w; ard = wa; wd = wdat; shift = s; sample_in = sin;
      @(posedge clk);
      x.name = name; x.v = ev; x.d1 = e1; x.d2 = e2;
      sb.push_back(x);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset.rd1", rd1, 16'h0);
      chk("reset.rd2", rd2, 16'h0);
      chk("reset.rd_valid", {15'd0, rd_valid}, 16'h0);
      @(negedge clk);
      rst = 1'b0;

      step("wr3",   1, 0,3'd0, 0,3'd0, 1,3'd3,16'h1234, 0,16'h0, 0,16'h0000,16'h0000);
      step("rd3",   1, 1,3'd3, 0,3'd0, 0,3'd0,16'h0,    0,16'h0, 1,16'h1234,16'h0000);

      // Asynchronous reset mid-cycle
      #2 rst = 1'b1;
      #1;
      chk("midrst.rd1", rd1, 16'h0);
      chk("midrst.rd2", rd2, 16'h0);
      chk("midrst.rd_valid", {15'd0, rd_valid}, 16'h0);
      @(negedge clk);
      rst = 1'b0;

      step("rd3post", 1, 1,3'd3, 0,3'd0, 0,3'd0,16'h0, 0,16'h0, 1,16'h0000,16'h0000);
      step("frzwr",   0, 1,3'd2, 0,3'd0, 1,3'd2,16'hAAAA, 0,16'h0, 1,16'h0000,16'h0000);
      step("rd2frz",  1, 1,3'd2, 0,3'd0, 0,3'd0,16'h0, 0,16'h0, 1,16'h0000,16'h0000);

      step("wr7",     1, 0,3'd0, 0,3'd0, 1,3'd7,16'h00FF, 0,16'h0, 0,16'h0000,16'h0000);
      step("rd7",     1, 1,3'd7, 0,3'd0, 0,3'd0,16'h0,    0,16'h0, 1,16'h00FF,16'h0000);
      step("wr6",     1, 0,3'd0, 0,3'd0, 1,3'd6,16'h6666, 0,16'h0, 0,16'h00FF,16'h0000);
      step("bypass",  1, 1,3'd5, 1,3'd5, 1,3'd5,16'hBEEF, 0,16'h0, 1,16'hBEEF,16'hBEEF);

      for (int i = 1; i <= 7; i++)
         step("shift", 1, 0,3'd0, 0,3'd0, 0,3'd0,16'h0, 1,16'(i), 0,16'hBEEF,16'hBEEF);

      step("line01",  1, 1,3'd0, 1,3'd1, 0,3'd0,16'h0, 0,16'h0, 1,16'h0007,16'h0006);
      step("line23",  1, 1,3'd2, 1,3'd3, 0,3'd0,16'h0, 0,16'h0, 1,16'h0005,16'h0004);
      step("line45",  1, 1,3'd4, 1,3'd5, 0,3'd0,16'h0, 0,16'h0, 1,16'h0003,16'h0002);
      step("upper67", 1, 1,3'd6, 1,3'd7, 0,3'd0,16'h0, 0,16'h0, 1,16'h6666,16'h00FF);

      step("collide", 1, 1,3'd0, 1,3'd1, 1,3'd0,16'h0022, 1,16'h0011, 1,16'h0022,16'h0007);
      step("after12", 1, 1,3'd1, 1,3'd2, 0,3'd0,16'h0, 0,16'h0, 1,16'h0007,16'h0006);

      step("idle",    1, 0,3'bxxx, 0,3'bxxx, 0,3'd0,16'h0, 0,16'h0, 0,16'h0007,16'h0006);
      step("rd07",    1, 1,3'd0, 1,3'd7, 0,3'd0,16'h0, 0,16'h0, 1,16'h0022,16'h00FF);
      step("frzsh",   0, 1,3'd1, 1,3'd2, 0,3'd0,16'h0, 1,16'h9999, 1,16'h0022,16'h00FF);
      step("rd01",    1, 1,3'd0, 1,3'd1, 0,3'd0,16'h0, 0,16'h0, 1,16'h0022,16'h0007);

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
